vector_test_host: RTL and testbench
===================================

VECTOR_TEST_HOST -- requirements
Module: vector_test_host

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- IN_WIDTH, 2, DUT stimulus width
- OUT_WIDTH, 1, DUT response width
- N_TESTS, 4, vector count (1..256)
- LATENCY, 0, cycles from stimulus to checked response (0..7)
- STOP_ON_FAIL, 0, 1 = stop at first mismatch
- AW, 8, vector address width
REQ-002 SHALL have ports (name, direction, width, meaning):
- sys_clk, in, 1, sole clock
- sys_rst_n, in, 1, asynchronous active-low reset
- cycle_count, in, 32, cycle number for log messages
- start, in, 1, begin run
- wr_en, in, 1, vector table write strobe
- wr_addr, in, AW, vector index
- wr_stim, in, IN_WIDTH, stimulus word
- wr_exp, in, OUT_WIDTH, expected response
- wr_mask, in, OUT_WIDTH, compare mask (1 = checked)
- sys_success, out, 1, run finished with no mismatch
- sys_fail, out, 1, run finished with at least one mismatch
- err_count, out, 16, mismatch count
- first_err_idx, out, AW, index of first mismatching vector
- clk, out, 1, DUT clock
- reset, out, 1, DUT reset, active-high
- dut_in, out, IN_WIDTH, registered stimulus
- dut_out, in, OUT_WIDTH, DUT response

Function
REQ-003 SHALL drive clk = sys_clk.
REQ-004 SHALL implement FSM IDLE, RUN, DRAIN, PASS, FAIL.
REQ-005 SHALL assert reset=1 in IDLE only; all other states reset=0.
REQ-006 SHALL accept table writes (wr_en, wr_addr < N_TESTS) only in IDLE, PASS and FAIL; writes in RUN/DRAIN or out of range SHALL be ignored.
REQ-007 SHALL act on start only in IDLE, PASS or FAIL: next state RUN, idx=0, err_count=0, first_err_idx=0, sys_success=sys_fail=0; start in RUN/DRAIN SHALL be ignored.
REQ-008 In RUN SHALL register dut_in=stim[idx] each cycle, idx+1; the vector issued with idx=N_TESTS-1 SHALL move the FSM to DRAIN, or to PASS/FAIL directly when LATENCY=0.
REQ-009 SHALL carry exp, mask and idx through a LATENCY-deep valid pipeline; a vector applied on dut_in in cycle t SHALL be checked against dut_out in cycle t+LATENCY.
REQ-010 Mismatch SHALL be ((dut_out ^ exp) & mask) != 0; mask=0 SHALL always pass.
REQ-011 Each mismatch SHALL increment err_count, saturating at 16'hFFFF; the first mismatch of a run SHALL load first_err_idx.
REQ-012 SHALL hold dut_in at 0 in IDLE, DRAIN, PASS and FAIL.
REQ-013 DRAIN SHALL last exactly LATENCY cycles; after the last check the next state SHALL be FAIL if err_count>0 (including a mismatch in that same check) else PASS.
REQ-014 With STOP_ON_FAIL=1, the first mismatch SHALL move the FSM to FAIL next cycle; in-flight checks SHALL be discarded and not counted.
REQ-015 sys_success SHALL be 1 only in PASS and sys_fail only in FAIL; they SHALL be registered, mutually exclusive and held until start or reset.
REQ-016 In simulation SHALL $display cycle_count, idx, dut_in, dut_out and exp on every mismatch, and a summary on entering PASS/FAIL.

Reset
REQ-017 sys_rst_n=0 SHALL asynchronously force: FSM=IDLE, idx=0, pipeline valid=0, dut_in=0, reset=1, sys_success=0, sys_fail=0, err_count=0, first_err_idx=0.
REQ-018 Reset SHALL NOT clear the vector table; contents SHALL survive reset.
REQ-019 Reset mid-RUN/DRAIN SHALL abandon the run, with no flag asserted.

Verification
REQ-020 Defaults, XOR table (00->0, 01->1, 11->0, 10->1), DUT c=a^b, start -> sys_success=1 after 4 RUN cycles, err_count=0.
REQ-021 LATENCY=2, DUT registers a^b twice -> PASS entered exactly 2 cycles after the last vector; sys_fail never 1.
REQ-022 STOP_ON_FAIL=0, exp[1]=0 wrong, exp[3]=0 wrong -> FAIL, err_count=2, first_err_idx=1.
REQ-023 STOP_ON_FAIL=1, same table -> FAIL the cycle after the idx 1 check, err_count=1, dut_in=0 thereafter.
REQ-024 mask[1]=0 with wrong exp[1] -> PASS; a second start after PASS reruns with cleared counters.
REQ-025 sys_rst_n low at the idx 2 cycle -> immediate IDLE, reset=1, flags 0; a restart without rewriting the table -> PASS.

Source files
------------

// File: rtl/vector_test_host.sv
// Vector test host: replays a stored stimulus table into an attached DUT,
// compares its responses against masked expected values and reports the
// result through sticky pass/fail flags.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | DUT held in reset, table writable, waiting for start
// S_RUN   | one vector per cycle on dut_in, responses being checked
// S_DRAIN | stimulus done, waiting LATENCY cycles for the last checks
// S_PASS  | run finished with no mismatch, table writable
// S_FAIL  | run finished with at least one mismatch, table writable
module vector_test_host #(
   parameter int IN_WIDTH     = 2,
   parameter int OUT_WIDTH    = 1,
   parameter int N_TESTS      = 4,
   parameter int LATENCY      = 0,
   parameter int STOP_ON_FAIL = 0,
   parameter int AW           = 8
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst_n,
   input  logic [31:0]          cycle_count,
   input  logic                 start,
   input  logic                 wr_en,
   input  logic [AW-1:0]        wr_addr,
   input  logic [IN_WIDTH-1:0]  wr_stim,
   input  logic [OUT_WIDTH-1:0] wr_exp,
   input  logic [OUT_WIDTH-1:0] wr_mask,
   output logic                 sys_success,
   output logic                 sys_fail,
   output logic [15:0]          err_count,
   output logic [AW-1:0]        first_err_idx,
   output logic                 clk,
   output logic                 reset,
   output logic [IN_WIDTH-1:0]  dut_in,
   input  logic [OUT_WIDTH-1:0] dut_out
);

   // Table is sized to a power of two so it can be indexed by the low bits of idx.
   localparam int            IW         = (N_TESTS > 1) ? $clog2(N_TESTS) : 1;
   localparam int            DEPTH      = 1 << IW;
   localparam logic [AW-1:0] LAST_IDX   = AW'(N_TESTS - 1);
   localparam logic [2:0]    DRAIN_LOAD = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_PASS, S_FAIL} state_t;

   state_t               state, state_nxt;
   logic [AW-1:0]        idx, idx_nxt;
   logic                 issue;
   logic [2:0]           drain_cnt;
   logic                 idle_like, running, wr_ok, start_ok, mism, flush;

   logic [IN_WIDTH-1:0]  stim_mem [DEPTH];
   logic [OUT_WIDTH-1:0] exp_mem  [DEPTH];
   logic [OUT_WIDTH-1:0] mask_mem [DEPTH];

   // Stage 0 lines up with dut_in; stage LATENCY lines up with the response.
   logic                 pv    [LATENCY+1];
   logic [OUT_WIDTH-1:0] pexp  [LATENCY+1];
   logic [OUT_WIDTH-1:0] pmask [LATENCY+1];
   logic [AW-1:0]        pidx  [LATENCY+1];

   assign clk       = sys_clk;
   assign reset     = (state == S_IDLE);
   assign idle_like = (state == S_IDLE) || (state == S_PASS) || (state == S_FAIL);
   assign running   = (state == S_RUN) || (state == S_DRAIN);
   assign wr_ok     = wr_en && idle_like && (32'(wr_addr) < N_TESTS);
   assign start_ok  = start && idle_like;
   assign mism      = running && pv[LATENCY] &&
                      (((dut_out ^ pexp[LATENCY]) & pmask[LATENCY]) != '0);
   assign flush     = !((state_nxt == S_RUN) || (state_nxt == S_DRAIN));

   // Next state, next vector index and whether a vector is launched this edge.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      issue     = 1'b0;
      case (state)
         S_IDLE, S_PASS, S_FAIL: begin
            if (start) begin
               state_nxt = S_RUN;
               idx_nxt   = '0;
               issue     = 1'b1;
            end
         end
         S_RUN: begin
            if ((STOP_ON_FAIL != 0) && mism) begin
               state_nxt = S_FAIL;
            end else if (idx == LAST_IDX) begin
               if (LATENCY == 0)
                  state_nxt = ((err_count != 16'd0) || mism) ? S_FAIL : S_PASS;
               else
                  state_nxt = S_DRAIN;
            end else begin
               idx_nxt = idx + 1'b1;
               issue   = 1'b1;
            end
         end
         S_DRAIN: begin
            if ((STOP_ON_FAIL != 0) && mism)
               state_nxt = S_FAIL;
            else if (drain_cnt == 3'd0)
               state_nxt = ((err_count != 16'd0) || mism) ? S_FAIL : S_PASS;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // State, stimulus, drain timer, result flags and error bookkeeping.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= S_IDLE;
         idx           <= '0;
         dut_in        <= '0;
         drain_cnt     <= 3'd0;
         sys_success   <= 1'b0;
         sys_fail      <= 1'b0;
         err_count     <= 16'd0;
         first_err_idx <= '0;
      end else begin
         state       <= state_nxt;
         idx         <= idx_nxt;
         dut_in      <= issue ? stim_mem[idx_nxt[IW-1:0]] : '0;
         sys_success <= (state_nxt == S_PASS);
         sys_fail    <= (state_nxt == S_FAIL);
         if ((state_nxt == S_DRAIN) && (state != S_DRAIN))
            drain_cnt <= DRAIN_LOAD;
         else if ((state == S_DRAIN) && (drain_cnt != 3'd0))
            drain_cnt <= drain_cnt - 1'b1;
         if (start_ok) begin
            err_count     <= 16'd0;
            first_err_idx <= '0;
         end else if (mism) begin
            if (err_count != 16'hFFFF)
               err_count <= err_count + 16'd1;
            if (err_count == 16'd0)
               first_err_idx <= pidx[LATENCY];
         end
      end
   end

   // Valid bits of the check pipeline; in-flight checks vanish when a run ends.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         for (int i = 0; i <= LATENCY; i++) pv[i] <= 1'b0;
      end else if (flush) begin
         for (int i = 0; i <= LATENCY; i++) pv[i] <= 1'b0;
      end else begin
         pv[0] <= issue;
         for (int i = 1; i <= LATENCY; i++) pv[i] <= pv[i-1];
      end
   end

   // Expected value, mask and index travelling alongside the valid bits.
   always_ff @(posedge sys_clk) begin
      pexp[0]  <= exp_mem[idx_nxt[IW-1:0]];
      pmask[0] <= mask_mem[idx_nxt[IW-1:0]];
      pidx[0]  <= idx_nxt;
      for (int i = 1; i <= LATENCY; i++) begin
         pexp[i]  <= pexp[i-1];
         pmask[i] <= pmask[i-1];
         pidx[i]  <= pidx[i-1];
      end
   end

   // Vector table; not reset so a loaded table survives a reset.
   always_ff @(posedge sys_clk) begin
      if (wr_ok) begin
         stim_mem[wr_addr[IW-1:0]] <= wr_stim;
         exp_mem[wr_addr[IW-1:0]]  <= wr_exp;
         mask_mem[wr_addr[IW-1:0]] <= wr_mask;
      end
   end

`ifndef SYNTHESIS
   // Simulation log of every miscompare and of each run outcome.
   always @(posedge sys_clk) begin
      if (sys_rst_n && mism)
         $display("[vth] cycle %0d: idx %0d dut_in %h dut_out %h exp %h differ",
                  cycle_count, pidx[LATENCY], dut_in, dut_out, pexp[LATENCY]);
      if (sys_rst_n && (state_nxt == S_PASS) && (state != S_PASS))
         $display("[vth] cycle %0d: run complete, all vectors matched", cycle_count);
      if (sys_rst_n && (state_nxt == S_FAIL) && (state != S_FAIL))
         $display("[vth] cycle %0d: run complete with miscompares", cycle_count);
   end
`endif

endmodule

// File: tb/tb_vector_test_host.sv
// Bench for vector_test_host: three hosts (combinational DUT, two-stage DUT
// with LATENCY=2, stop-on-first-miscompare) share the table bus and start.
module tb_vector_test_host;

   logic        sys_clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic [31:0] cycle_count = 32'd0;
   logic        start = 1'b0;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_addr = 8'd0;
   logic [1:0]  wr_stim = 2'd0;
   logic        wr_exp = 1'b0;
   logic        wr_mask = 1'b0;

   logic        s0, f0, c0, r0, dout0;
   logic [15:0] e0;
   logic [7:0]  fi0;
   logic [1:0]  din0;
   logic        s2, f2, c2, r2, dout2;
   logic [15:0] e2;
   logic [7:0]  fi2;
   logic [1:0]  din2;
   logic        ss, fs, cs, rs, douts;
   logic [15:0] es;
   logic [7:0]  fis;
   logic [1:0]  dins;

   logic        dq1 = 1'b0, dq2 = 1'b0;

   always #5 sys_clk = ~sys_clk;
   always @(negedge sys_clk) cycle_count = cycle_count + 32'd1;

   assign dout0 = ^din0;
   assign douts = ^dins;
   always @(posedge c2) begin
      dq1 <= ^din2;
      dq2 <= dq1;
   end
   assign dout2 = dq2;

   vector_test_host u_l0 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cycle_count(cycle_count),
      .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
      .wr_exp(wr_exp), .wr_mask(wr_mask), .sys_success(s0), .sys_fail(f0),
      .err_count(e0), .first_err_idx(fi0), .clk(c0), .reset(r0),
      .dut_in(din0), .dut_out(dout0));

   vector_test_host #(.LATENCY(2)) u_l2 (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cycle_count(cycle_count),
      .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
      .wr_exp(wr_exp), .wr_mask(wr_mask), .sys_success(s2), .sys_fail(f2),
      .err_count(e2), .first_err_idx(fi2), .clk(c2), .reset(r2),
      .dut_in(din2), .dut_out(dout2));

   vector_test_host #(.STOP_ON_FAIL(1)) u_sf (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .cycle_count(cycle_count),
      .start(start), .wr_en(wr_en), .wr_addr(wr_addr), .wr_stim(wr_stim),
      .wr_exp(wr_exp), .wr_mask(wr_mask), .sys_success(ss), .sys_fail(fs),
      .err_count(es), .first_err_idx(fis), .clk(cs), .reset(rs),
      .dut_in(dins), .dut_out(douts));

   typedef struct {
      string    name;
      logic [3:0] exp;
      logic [3:0] mask;
      int       n_err;
      int       first;
   } vec_t;

   typedef struct {
      bit pass;
      int err;
      int first;
      int lat;
   } res_t;

   logic [1:0] stim_tbl [4];
   vec_t       tbl [7];
   res_t       q0[$], q2[$], qs[$];
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic write_table(input vec_t v);
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         wr_en   = 1'b1;
         wr_addr = 8'(i);
         wr_stim = stim_tbl[i];
         wr_exp  = v.exp[i];
         wr_mask = v.mask[i];
      end
      @(negedge sys_clk);
      wr_en = 1'b0;
   endtask

   task automatic cmp(input string tag, input res_t e, input logic s, input logic f,
                      input logic [15:0] ec, input logic [7:0] fi, input int lat);
      chk({tag, "/success"}, s, e.pass);
      chk({tag, "/fail"}, f, !e.pass);
      chk({tag, "/err_count"}, ec, e.err);
      chk({tag, "/first_err_idx"}, fi, e.first);
      chk({tag, "/latency"}, lat, e.lat);
   endtask

   // One run on all three hosts; disturb adds a table write and a start mid-run.
   task automatic run(input vec_t v, input bit disturb);
      res_t e;
      int n, l0, l2, ls;
      e.pass  = (v.n_err == 0);
      e.err   = v.n_err;
      e.first = v.first;
      e.lat   = 4;
      q0.push_back(e);
      e.lat   = 6;
      q2.push_back(e);
      e.err   = (v.n_err > 0) ? 1 : 0;
      e.lat   = (v.n_err > 0) ? v.first + 1 : 4;
      qs.push_back(e);

      @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      chk({v.name, "/cleared_err"}, e0, 0);
      chk({v.name, "/cleared_flags"}, {s0, f0}, 0);
      chk({v.name, "/run_reset"}, r0, 0);

      n = 0; l0 = -1; l2 = -1; ls = -1;
      while (n < 40) begin
         if (l0 < 0 && (s0 || f0)) l0 = n;
         if (l2 < 0 && (s2 || f2)) l2 = n;
         if (ls < 0 && (ss || fs)) ls = n;
         if (l0 < 0 && n < 4) chk({v.name, "/dut_in"}, din0, stim_tbl[n]);
         if (disturb && n == 1) begin
            wr_en = 1'b1; wr_addr = 8'd3; wr_stim = 2'b10; wr_exp = 1'b0; wr_mask = 1'b1;
            start = 1'b1;
         end
         if (disturb && n == 2) begin
            wr_en = 1'b0;
            start = 1'b0;
         end
         if (l0 >= 0 && l2 >= 0 && ls >= 0) break;
         @(negedge sys_clk);
         n++;
      end
      chk({v.name, "/done_in_time"}, (l0 >= 0 && l2 >= 0 && ls >= 0), 1);

      cmp({v.name, "/l0"}, q0.pop_front(), s0, f0, e0, fi0, l0);
      cmp({v.name, "/l2"}, q2.pop_front(), s2, f2, e2, fi2, l2);
      cmp({v.name, "/sf"}, qs.pop_front(), ss, fs, es, fis, ls);
      chk({v.name, "/excl_l2"}, s2 & f2, 0);
      chk({v.name, "/idle_din_l0"}, din0, 0);
      chk({v.name, "/idle_din_sf"}, dins, 0);
      chk({v.name, "/done_reset"}, r0, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      stim_tbl[0] = 2'b00; stim_tbl[1] = 2'b01; stim_tbl[2] = 2'b11; stim_tbl[3] = 2'b10;
      // exp bit i is the expected response of vector i; correct pattern is 4'b1010.
      tbl[0] = '{"all_ok",   4'b1010, 4'b1111, 0, 0};
      tbl[1] = '{"two_bad",  4'b0000, 4'b1111, 2, 1};
      tbl[2] = '{"masked",   4'b1000, 4'b1101, 0, 0};
      tbl[3] = '{"all_inv",  4'b0101, 4'b1111, 4, 0};
      tbl[4] = '{"mask_off", 4'b0101, 4'b0000, 0, 0};
      tbl[5] = '{"last_bad", 4'b0010, 4'b1111, 1, 3};
      tbl[6] = '{"rerun_ok", 4'b1010, 4'b1111, 0, 0};

      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      chk("rst/reset", r0, 1);
      chk("rst/flags", {s0, f0}, 0);
      chk("rst/err_count", e0, 0);
      chk("rst/first_err_idx", fi0, 0);
      chk("rst/dut_in", din0, 0);
      chk("rst/reset_sf", rs, 1);
      sys_rst_n = 1'b1;

      for (int k = 0; k < 7; k++) begin
         write_table(tbl[k]);
         run(tbl[k], 1'b0);
      end

      // Out-of-range write would alias onto entry 0 if it were accepted.
      @(negedge sys_clk);
      wr_en = 1'b1; wr_addr = 8'd4; wr_stim = 2'b00; wr_exp = 1'b1; wr_mask = 1'b1;
      @(negedge sys_clk);
      wr_en = 1'b0;

      // Reset in the middle of a run, at the idx 2 cycle.
      @(negedge sys_clk);
      start = 1'b1;
      @(negedge sys_clk);
      start = 1'b0;
      @(negedge sys_clk);
      @(negedge sys_clk);
      chk("midrst/din_idx2", din0, stim_tbl[2]);
      #2 sys_rst_n = 1'b0;
      #1;
      chk("midrst/reset", r0, 1);
      chk("midrst/flags", {s0, f0}, 0);
      chk("midrst/err_count", e0, 0);
      chk("midrst/dut_in", din0, 0);
      chk("midrst/reset_l2", r2, 1);
      chk("midrst/flags_sf", {ss, fs}, 0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;

      run('{"after_rst", 4'b1010, 4'b1111, 0, 0}, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
